// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit.
// Holds size/state encodings, data word width, request lane bundle.
package mem_access_pkg;

    localparam int SLOT_SIZE = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_RMW   = 2'b10,
        S_STORE = 2'b11
    } state_e;

    typedef struct packed {
        size_e      size;
        logic       uns;
        logic [1:0] off;
    } lane_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Lane extract/extend for loads and byte/half merge for stores.
// Ports: i_rdata memory word, i_wdata store data, i_req size/sign/offset; o_load, o_merged.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [SLOT_SIZE-1:0] i_rdata,
    input  logic [SLOT_SIZE-1:0] i_wdata,
    input  lane_req_t            i_req,
    output logic [SLOT_SIZE-1:0] o_load,
    output logic [SLOT_SIZE-1:0] o_merged
);

    logic [4:0]           sh_amt;
    logic [SLOT_SIZE-1:0] lane;
    logic [SLOT_SIZE-1:0] mask;
    logic                 sx;

    assign sh_amt = {i_req.off, 3'b000};
    assign lane   = i_rdata >> sh_amt;

    always_comb begin
        o_load = lane;
        mask   = '1;
        sx     = 1'b0;
        unique case (1'b1)
            (i_req.size == SZ_BYTE): begin
                sx     = ~i_req.uns & lane[7];
                o_load = {{24{sx}}, lane[7:0]};
                mask   = 32'h0000_00ff << sh_amt;
            end
            (i_req.size == SZ_HALF): begin
                sx     = ~i_req.uns & lane[15];
                o_load = {{16{sx}}, lane[15:0]};
                mask   = 32'h0000_ffff << sh_amt;
            end
            default: ;
        endcase
    end

    // word case: mask is all ones, shift is zero, so merged == wdata
    assign o_merged = (i_rdata & ~mask) | ((i_wdata << sh_amt) & mask);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-addressed data_memory.
// Ports: valid/ready request (rd, wr, size, unsigned, addr, wdata), o_rdata/o_done/o_misaligned, o_mem_* memory side.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int SLOT_SIZE = mem_access_pkg::SLOT_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_mem_rd,
    input  logic                 i_mem_wr,
    input  logic [1:0]           i_size,
    input  logic                 i_unsigned,
    input  logic [ADDR_SIZE+1:0] i_addr,
    input  logic [SLOT_SIZE-1:0] i_wdata,
    output logic [SLOT_SIZE-1:0] o_rdata,
    output logic                 o_done,
    output logic                 o_misaligned,
    output logic                 o_mem_wr_rd,
    output logic [ADDR_SIZE-1:0] o_mem_addr,
    output logic [SLOT_SIZE-1:0] o_mem_wdata,
    input  logic [SLOT_SIZE-1:0] i_mem_rdata
);

    state_e               state_q;
    state_e               state_d;
    lane_req_t            req_q;
    lane_req_t            req_d;
    logic [SLOT_SIZE-1:0] wdata_q;
    logic [SLOT_SIZE-1:0] load_data;
    logic [SLOT_SIZE-1:0] merged;
    size_e                size_in;
    logic                 accept;
    logic                 illegal;
    logic                 go;

    assign size_in     = size_e'(i_size);
    assign o_ready     = (state_q == S_IDLE);
    assign o_mem_wr_rd = (state_q == S_STORE);
    assign accept      = i_valid & o_ready;
    assign req_d       = {size_in, i_unsigned, i_addr[1:0]};

    assign illegal = (i_mem_rd & i_mem_wr)
                   | (size_in == SZ_ILL)
                   | ((size_in == SZ_HALF) & i_addr[0])
                   | ((size_in == SZ_WORD) & (i_addr[1:0] != 2'b00));

    // go: a legal request that actually touches memory
    assign go = accept & ~illegal & (i_mem_rd | i_mem_wr);

    mem_lane_align u_align (
        .i_rdata  (i_mem_rdata),
        .i_wdata  (wdata_q),
        .i_req    (req_q),
        .o_load   (load_data),
        .o_merged (merged)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (i_mem_rd) begin
                        state_d = S_LOAD;
                    end else if (size_in == SZ_WORD) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW;
                    end
                end
            end
            S_LOAD:  state_d = S_IDLE;
            S_RMW:   state_d = S_STORE;
            S_STORE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            wdata_q      <= '0;
            o_rdata      <= '0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
        end else begin
            state_q      <= state_d;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            if (accept) begin
                req_q        <= req_d;
                wdata_q      <= i_wdata;
                // errors and no-ops complete without leaving IDLE
                o_done       <= ~go;
                o_misaligned <= illegal;
            end
            if (go) begin
                o_mem_addr  <= i_addr[ADDR_SIZE+1:2];
                o_mem_wdata <= i_wdata;
            end
            case (state_q)
                S_LOAD: begin
                    o_rdata <= load_data;
                    o_done  <= 1'b1;
                end
                S_RMW:   o_mem_wdata <= merged;
                S_STORE: o_done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed requests, queue-based model, per-cycle compare.
// Ports: none.
module tb_mem_access_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          valid = 1'b0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic          uns = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [AW+1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic          ready;
    logic [31:0]   rdata;
    logic          done;
    logic          mis;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0] mem [32] = '{default: '0};
    logic [31:0] ref_mem [32] = '{default: '0};

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] model_rdata = '0;

    typedef struct {
        int          done_cyc;
        logic        mis;
        logic        is_load;
        logic        is_wr;
        logic [31:0] ldata;
        logic [4:0]  waddr;
        logic [31:0] wword;
    } exp_t;

    exp_t q[$];
    exp_t e_cur;
    logic x_done;
    logic x_busy;
    logic x_wr;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_SIZE (AW),
        .SLOT_SIZE (32)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_mem_rd     (rd),
        .i_mem_wr     (wr),
        .i_size       (size),
        .i_unsigned   (uns),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rdata      (rdata),
        .o_done       (done),
        .o_misaligned (mis),
        .o_mem_wr_rd  (mem_wr),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic m_illegal(logic r, logic w, logic [1:0] sz,
                                       logic [6:0] a);
        int ia = int'(a);
        return (r && w) || (sz == 2'd3)
            || (sz == 2'd1 && ia % 2 != 0)
            || (sz == 2'd2 && ia % 4 != 0);
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] w, logic [1:0] sz,
                                           logic u, logic [1:0] off);
        logic [31:0] v;
        if (sz == 2'd2) return w;
        v = w >> (8 * int'(off));
        if (sz == 2'd0) begin
            v = v % 256;
            if (!u && v >= 128) v = v | 32'hFFFF_FF00;
        end else begin
            v = v % 65536;
            if (!u && v >= 32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(logic [31:0] w, logic [31:0] d,
                                            logic [1:0] sz, logic [1:0] off);
        logic [7:0] b [4];
        int n;
        for (int i = 0; i < 4; i++) b[i] = 8'(w >> (8 * i));
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) b[int'(off) + i] = 8'(d >> (8 * i));
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // per-cycle compare against the expectation queue
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            model_rdata = '0;
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_mis", 32'(mis), 32'd0);
            chk("rst_wr_rd", 32'(mem_wr), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
        end else begin
            x_done = 1'b0;
            x_busy = 1'b0;
            x_wr   = 1'b0;
            if (q.size() != 0) begin
                e_cur  = q[0];
                x_done = (cyc == e_cur.done_cyc);
                x_busy = (cyc < e_cur.done_cyc);
                x_wr   = e_cur.is_wr && (cyc == e_cur.done_cyc - 1);
            end
            chk("ready", 32'(ready), 32'(!x_busy));
            chk("done", 32'(done), 32'(x_done));
            chk("wr_rd", 32'(mem_wr), 32'(x_wr));
            if (x_wr) begin
                chk("wr_addr", 32'(mem_addr), 32'(e_cur.waddr));
                chk("wr_data", mem_wdata, e_cur.wword);
            end
            if (x_done) begin
                chk("misaligned", 32'(mis), 32'(e_cur.mis));
                if (e_cur.is_load) model_rdata = e_cur.ldata;
                if (e_cur.is_wr) begin
                    ref_mem[e_cur.waddr] = e_cur.wword;
                    chk("mem_word", mem[e_cur.waddr], e_cur.wword);
                end
                void'(q.pop_front());
            end else begin
                chk("mis_quiet", 32'(mis), 32'd0);
            end
            chk("rdata", rdata, model_rdata);
        end
    end

    task automatic issue(input logic r, input logic w, input logic [1:0] sz,
                         input logic u, input logic [6:0] a,
                         input logic [31:0] d);
        exp_t e;
        int   n;
        logic [1:0] off;
        logic [4:0] wa;
        logic ill;
        valid = 1'b1;
        rd    = r;
        wr    = w;
        size  = sz;
        uns   = u;
        addr  = a;
        wdata = d;
        n = 0;
        while (!ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept", 32'(ready), 32'd1);
        if (!ready) begin
            valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        off = a[1:0];
        wa  = a[6:2];
        ill = m_illegal(r, w, sz, a);
        e.done_cyc = cyc;
        e.mis      = ill;
        e.is_load  = 1'b0;
        e.is_wr    = 1'b0;
        e.ldata    = '0;
        e.waddr    = wa;
        e.wword    = '0;
        if (!ill && r) begin
            e.is_load  = 1'b1;
            e.ldata    = m_load(ref_mem[wa], sz, u, off);
            e.done_cyc = cyc + 1;
        end else if (!ill && w) begin
            e.is_wr    = 1'b1;
            e.wword    = m_store(ref_mem[wa], d, sz, off);
            e.done_cyc = cyc + ((sz == 2'd2) ? 1 : 2);
        end
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        valid = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        if (q.size() != 0) q.delete();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 1, 2'd2, 0, 7'h08, 32'hDEADBEEF);
        drain();
        chk("sw_mem2", mem[2], 32'hDEADBEEF);

        issue(1, 0, 2'd0, 0, 7'h0B, 32'h0);
        drain();
        chk("lb_0b", rdata, 32'hFFFFFFDE);
        issue(1, 0, 2'd0, 1, 7'h0B, 32'h0);
        drain();
        chk("lbu_0b", rdata, 32'h000000DE);
        issue(1, 0, 2'd1, 0, 7'h0A, 32'h0);
        drain();
        chk("lh_0a", rdata, 32'hFFFFDEAD);
        issue(1, 0, 2'd1, 1, 7'h08, 32'h0);
        drain();
        chk("lhu_08", rdata, 32'h0000BEEF);
        issue(1, 0, 2'd2, 0, 7'h08, 32'h0);
        drain();
        chk("lw_08", rdata, 32'hDEADBEEF);

        issue(0, 1, 2'd0, 0, 7'h09, 32'hFFFFFF55);
        drain();
        chk("sb_09", mem[2], 32'hDEAD55EF);
        issue(0, 1, 2'd1, 0, 7'h0A, 32'h00001234);
        drain();
        chk("sh_0a", mem[2], 32'h123455EF);

        issue(1, 0, 2'd2, 0, 7'h06, 32'h0);
        drain();
        issue(0, 1, 2'd1, 0, 7'h03, 32'hAAAA5555);
        drain();
        issue(1, 0, 2'd3, 0, 7'h08, 32'h0);
        drain();
        issue(1, 1, 2'd2, 0, 7'h08, 32'h0);
        drain();
        issue(0, 0, 2'd2, 0, 7'h08, 32'h0);
        drain();
        chk("err_rdata_held", rdata, 32'hDEADBEEF);
        chk("err_mem0", mem[0], 32'h0);
        chk("err_mem1", mem[1], 32'h0);
        chk("err_mem2", mem[2], 32'h123455EF);

        issue(0, 1, 2'd0, 0, 7'h09, 32'h00000077);
        valid = 1'b0;
        wr    = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        chk("abort_mem2", mem[2], 32'h123455EF);
        chk("abort_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        issue(1, 0, 2'd2, 0, 7'h08, 32'h0);
        drain();
        chk("post_rst_lw", rdata, 32'h123455EF);

        issue(1, 0, 2'd2, 0, 7'h08, 32'h0);
        issue(0, 1, 2'd2, 0, 7'h10, 32'hCAFEF00D);
        issue(1, 0, 2'd0, 0, 7'h13, 32'h0);
        drain();
        chk("b2b_lb", rdata, 32'hFFFFFFCA);
        chk("b2b_mem4", mem[4], 32'hCAFEF00D);

        issue(1, 0, 2'd1, 1, 7'h12, 32'h0);
        issue(1, 0, 2'd0, 0, 7'h10, 32'h0);
        drain();
        chk("lb_10", rdata, 32'h0000000D);
        issue(1, 0, 2'd1, 0, 7'h12, 32'h0);
        drain();
        chk("lh_12", rdata, 32'hFFFFCAFE);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
